// File: rtl/peso_display_7seg.sv
// Display stage for the grams-to-kilograms converter: sequential double-dabble
// BCD conversion of kg_int/kg_frac, held and scanned onto a 5-digit "II.FFF" display.
module peso_display_7seg #(
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] kg_int,
  input  logic [13:0] kg_frac,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [4:0]  an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRES_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CONV_INT  = 2'd1,
    S_CONV_FRAC = 2'd2,
    S_COMMIT    = 2'd3
  } state_e;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift the
  // binary MSB into the BCD field. Returns {bcd[11:0], bin[13:0]}.
  function automatic logic [25:0] dabble_step(input logic [11:0] bcd,
                                              input logic [13:0] bin);
    logic [11:0] adj;
    adj = 12'd0;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return {adj[10:0], bin, 1'b0};
  endfunction

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  state_e       state_q;
  logic         busy_q;
  logic         ovf_q;
  logic [13:0]  bin_q;
  logic [13:0]  frac_q;
  logic [11:0]  bcd_q;
  logic [3:0]   cnt_q;
  logic [7:0]   int_bcd_q;
  logic [19:0]  dig_q;
  logic         disp_ovf_q;
  logic         blank_q;

  logic [PW-1:0] pres_q;
  logic [2:0]    idx_q;

  logic [25:0]  step_d;
  logic [3:0]   cur_dig_s;
  logic [6:0]   seg_h_s;
  logic         dp_h_s;
  logic [4:0]   an_h_s;

  assign step_d = dabble_step(bcd_q, bin_q);

  // Conversion FSM: capture, two 14-cycle dabble passes, then commit to display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bin_q      <= 14'd0;
      frac_q     <= 14'd0;
      bcd_q      <= 12'd0;
      cnt_q      <= 4'd0;
      int_bcd_q  <= 8'd0;
      dig_q      <= 20'd0;
      disp_ovf_q <= 1'b0;
      blank_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            bin_q  <= kg_int;
            frac_q <= kg_frac;
            bcd_q  <= 12'd0;
            cnt_q  <= 4'd0;
            busy_q <= 1'b1;
            if ((kg_int > 14'd99) || (kg_frac > 14'd999)) begin
              ovf_q   <= 1'b1;
              state_q <= S_COMMIT;
            end else begin
              ovf_q   <= 1'b0;
              state_q <= S_CONV_INT;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONV_INT: begin
          if (cnt_q == LAST_BIT) begin
            // Value is at most 99, so only the two low BCD digits matter.
            int_bcd_q <= step_d[21:14];
            bin_q     <= frac_q;
            bcd_q     <= 12'd0;
            cnt_q     <= 4'd0;
            state_q   <= S_CONV_FRAC;
          end else begin
            {bcd_q, bin_q} <= step_d;
            cnt_q          <= cnt_q + 4'd1;
          end
        end
        S_CONV_FRAC: begin
          {bcd_q, bin_q} <= step_d;
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= 4'd0;
            state_q <= S_COMMIT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_COMMIT: begin
          dig_q      <= {int_bcd_q, bcd_q};
          disp_ovf_q <= ovf_q;
          blank_q    <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running digit scanner: advance one digit per REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_q <= '0;
      idx_q  <= 3'd0;
    end else if (pres_q == PRES_MAX) begin
      pres_q <= '0;
      idx_q  <= (idx_q >= 3'd4) ? 3'd0 : idx_q + 3'd1;
    end else begin
      pres_q <= pres_q + PW'(1);
    end
  end

  // Active-high digit rendering with tens blanking and overflow dashes.
  always_comb begin
    cur_dig_s = 4'd0;
    seg_h_s   = 7'd0;
    dp_h_s    = 1'b0;
    an_h_s    = 5'd0;
    case (idx_q)
      3'd0:    cur_dig_s = dig_q[3:0];
      3'd1:    cur_dig_s = dig_q[7:4];
      3'd2:    cur_dig_s = dig_q[11:8];
      3'd3:    cur_dig_s = dig_q[15:12];
      3'd4:    cur_dig_s = dig_q[19:16];
      default: cur_dig_s = 4'd0;
    endcase
    if (!blank_q) begin
      an_h_s = 5'd1 << idx_q;
      if (disp_ovf_q) begin
        seg_h_s = 7'b1000000;
      end else if ((idx_q == 3'd4) && (cur_dig_s == 4'd0)) begin
        seg_h_s = 7'd0;
      end else begin
        seg_h_s = seg_pattern(cur_dig_s);
      end
      dp_h_s = (idx_q == 3'd3) && !disp_ovf_q;
    end else begin
      an_h_s  = 5'd0;
      seg_h_s = 7'd0;
      dp_h_s  = 1'b0;
    end
  end

  assign busy = busy_q;
  assign seg  = (ACTIVE_LOW != 0) ? ~seg_h_s : seg_h_s;
  assign dp   = (ACTIVE_LOW != 0) ? ~dp_h_s  : dp_h_s;
  assign an   = (ACTIVE_LOW != 0) ? ~an_h_s  : an_h_s;

endmodule

// File: tb/tb_peso_display_7seg.sv
// Self-checking bench for peso_display_7seg: directed and random loads compared
// against an arithmetic reference of the displayed digits and scan position.
module tb_peso_display_7seg;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [13:0] kg_int;
  logic [13:0] kg_frac;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  an;

  int checks = 0;
  int errors = 0;
  int cyc;

  bit exp_blank;
  bit exp_ovf;
  int exp_dig [5];
  logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  peso_display_7seg #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .kg_int(kg_int), .kg_frac(kg_frac),
    .busy(busy), .seg(seg), .dp(dp), .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_disp(input string tag);
    int idx;
    logic [6:0] s_h, s_l;
    logic       d_h, d_l;
    logic [4:0] a_h, a_l;
    idx = (cyc / DIV) % 5;
    s_h = 7'd0; d_h = 1'b0; a_h = 5'd0;
    if (!exp_blank) begin
      a_h = 5'(1 << idx);
      if (exp_ovf) begin
        s_h = 7'h40;
      end else begin
        s_h = (idx == 4 && exp_dig[4] == 0) ? 7'd0 : pat_tbl[exp_dig[idx]];
        d_h = (idx == 3);
      end
    end
    s_l = ~s_h; d_l = ~d_h; a_l = ~a_h;
    chk({tag, "_an"},  an,  a_l);
    chk({tag, "_seg"}, seg, s_l);
    chk({tag, "_dp"},  dp,  d_l);
  endtask

  task automatic conv(input int ki, input int kf, input int intf);
    int lat;
    bit ovf_n;
    ovf_n = (ki > 99) || (kf > 999);
    lat = ovf_n ? 1 : 29;
    @(negedge clk); load = 1'b1; kg_int = 14'(ki); kg_frac = 14'(kf);
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < lat; k++) begin
      chk("busy_hi", busy, 1);
      chk_disp("hold");
      if (k == intf - 1) begin
        load = 1'b1; kg_int = 14'd99; kg_frac = 14'd999;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    exp_ovf = ovf_n;
    exp_blank = 1'b0;
    exp_dig[4] = ki / 10;
    exp_dig[3] = ki % 10;
    exp_dig[2] = kf / 100;
    exp_dig[1] = (kf / 10) % 10;
    exp_dig[0] = kf % 10;
    chk("busy_lo", busy, 0);
    chk_disp("commit");
  endtask

  task automatic model_reset();
    exp_blank = 1'b1;
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) exp_dig[i] = 0;
  endtask

  task automatic watch(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_disp(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; kg_int = 14'd0; kg_frac = 14'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk_disp("rst");
    rst_n = 1'b1;
    watch(6, "blank_after_rst");

    conv(12, 345, -1);
    watch(25, "scan_12_345");
    conv(5, 7, -1);
    watch(22, "scan_5_007");
    conv(100, 0, -1);
    watch(6, "ovf_int");
    conv(3, 1000, -1);
    watch(6, "ovf_frac");
    conv(12, 345, 10);
    watch(8, "busy_ignore");
    conv(99, 999, -1);
    watch(8, "max");

    // Abort during the fraction pass.
    @(negedge clk); load = 1'b1; kg_int = 14'd12; kg_frac = 14'd345;
    @(negedge clk); load = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_mid", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_busy", busy, 0);
    chk_disp("rst_async");
    repeat (2) @(negedge clk);
    chk_disp("rst_hold");
    rst_n = 1'b1;
    watch(35, "blank_after_abort");
    conv(0, 0, -1);
    watch(21, "zero");

    for (int r = 0; r < 20; r++) begin
      int ki, kf;
      ki = int'($urandom_range(0, 110));
      kf = int'($urandom_range(0, 1020));
      conv(ki, kf, -1);
      watch(int'($urandom_range(1, 12)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
